// File: rtl/clock_core_param.sv
// clock_core_param: prescaled HH:MM:SS clock with validated load, set pulses,
// run/hold, 12/24-hour BCD display digits and second/day strobes.
module clock_core_param #(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter logic [16:0] RESET_TIME = 17'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [16:0] time_in,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic        mode_12h,
  output logic [4:0]  hour_out,
  output logic [5:0]  min_out,
  output logic [5:0]  sec_out,
  output logic [3:0]  sec_1s,
  output logic [3:0]  sec_10s,
  output logic [3:0]  min_1s,
  output logic [3:0]  min_10s,
  output logic [3:0]  hr_1s,
  output logic [3:0]  hr_10s,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_tick,
  output logic        load_err
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  logic [PW-1:0] cnt_q, cnt_d;
  logic [4:0] hour_q, hour_d, h_nx, disp_hr;
  logic [5:0] min_q, min_d, sec_q, sec_d, m_nx, s_nx;
  logic sec_tick_q, sec_tick_d, day_tick_q, day_tick_d, load_err_q, load_err_d;
  logic tick, ld_ok, adv, wrap_s, wrap_m, wrap_h;
  assign wrap_s = sec_q == 6'd59;
  assign wrap_m = min_q == 6'd59;
  assign wrap_h = hour_q == 5'd23;
  assign s_nx = wrap_s ? 6'd0 : sec_q + 6'd1;
  assign m_nx = wrap_m ? 6'd0 : min_q + 6'd1;
  assign h_nx = wrap_h ? 5'd0 : hour_q + 5'd1;
  assign tick = run && cnt_q == LAST;
  assign ld_ok = time_in[16:12] <= 5'd23 && time_in[11:6] <= 6'd59 && time_in[5:0] <= 6'd59;
  // a tick only advances time when no load or set pulse claims the cycle
  assign adv = tick && !load && !inc_hr && !inc_min;
  always_comb begin
    cnt_d = (load && ld_ok) ? '0 : !run ? cnt_q : tick ? '0 : cnt_q + PW'(1);
    hour_d = hour_q;
    min_d = min_q;
    sec_d = sec_q;
    if (load) begin
      if (ld_ok) {hour_d, min_d, sec_d} = time_in;
    end else if (inc_hr || inc_min) begin
      if (inc_hr) hour_d = h_nx;
      if (inc_min) min_d = m_nx;
    end else if (tick) begin
      sec_d = s_nx;
      if (wrap_s) min_d = m_nx;
      if (wrap_s && wrap_m) hour_d = h_nx;
    end
    sec_tick_d = adv;
    day_tick_d = adv && wrap_s && wrap_m && wrap_h;
    load_err_d = load && !ld_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      {hour_q, min_q, sec_q} <= RESET_TIME;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hour_q <= hour_d;
      min_q <= min_d;
      sec_q <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end
  assign disp_hr = !mode_12h ? hour_q : (hour_q == 5'd0) ? 5'd12 : (hour_q > 5'd12) ? hour_q - 5'd12 : hour_q;
  assign hour_out = hour_q;
  assign min_out = min_q;
  assign sec_out = sec_q;
  assign sec_10s = 4'(sec_q / 6'd10);
  assign sec_1s = 4'(sec_q % 6'd10);
  assign min_10s = 4'(min_q / 6'd10);
  assign min_1s = 4'(min_q % 6'd10);
  assign hr_10s = 4'(disp_hr / 5'd10);
  assign hr_1s = 4'(disp_hr % 5'd10);
  assign pm = hour_q >= 5'd12;
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;
  assign load_err = load_err_q;
endmodule
